gcd_stein: RTL and testbench



---
 rtl/gcd_stein.sv | 139 +++++++++++++
 tb/tb_gcd_stein.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/gcd_stein.sv
// gcd_stein: multicycle binary (Stein) GCD with optional signed operands.
// Define GCD_LCM_EN to add the DIV/MUL states and the lo (LCM) output.
module gcd_stein #(
    parameter int NBits = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [NBits-1:0] xi,
    input  logic [NBits-1:0] yi,
    output logic [NBits-1:0] xo,
    output logic             rdy,
    output logic             busy
`ifdef GCD_LCM_EN
    ,
    output logic [2*NBits-1:0] lo
`endif
);
    localparam int KW = $clog2(NBits + 1);
`ifdef GCD_LCM_EN
    typedef enum logic [2:0] {IDLE, CHK, EVEN, ODD, DIV, MUL, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, CHK, EVEN, ODD, DONE} state_t;
`endif
    state_t state_q;
    logic [NBits-1:0] a_q, b_q, xo_q, xm_d, ym_d;
    logic [KW-1:0] k_q;
    logic chk_q, rdy_q, busy_q;
    // the most negative value negates to itself, which is its correct unsigned magnitude
    assign xm_d = (sgn && xi[NBits-1]) ? -xi : xi;
    assign ym_d = (sgn && yi[NBits-1]) ? -yi : yi;
`ifdef GCD_LCM_EN
    logic [NBits-1:0] xm_q, ym_q, g_q, rem_q, quo_q;
    logic [KW-1:0] cnt_q;
    logic [2*NBits-1:0] acc_q, mc_q, lo_q, acc_d;
    logic [NBits:0] shift_d;
    logic ge_d;
    assign shift_d = {rem_q, quo_q[NBits-1]};
    assign ge_d = shift_d >= {1'b0, g_q};
    assign acc_d = acc_q + (quo_q[0] ? mc_q : '0);
    assign lo = lo_q;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            k_q <= '0;
            chk_q <= 1'b0;
            xo_q <= '0;
            rdy_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef GCD_LCM_EN
            lo_q <= '0;
            cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    a_q <= xm_d;
                    b_q <= ym_d;
                    k_q <= '0;
                    chk_q <= 1'b0;
                    rdy_q <= 1'b0;
                    busy_q <= 1'b1;
                    state_q <= CHK;
`ifdef GCD_LCM_EN
                    xm_q <= xm_d;
                    ym_q <= ym_d;
`endif
                end
                // first CHK cycle only arms the check so results land two edges after start
                CHK: if (!chk_q) chk_q <= 1'b1;
                else if (a_q == '0 || b_q == '0) begin
                    xo_q <= a_q | b_q;
                    rdy_q <= 1'b1;
                    busy_q <= 1'b0;
                    state_q <= DONE;
`ifdef GCD_LCM_EN
                    lo_q <= '0;
`endif
                end else state_q <= EVEN;
                EVEN: if (!a_q[0] && !b_q[0]) begin
                    a_q <= a_q >> 1;
                    b_q <= b_q >> 1;
                    k_q <= k_q + 1'b1;
                end else state_q <= ODD;
                ODD: if (!a_q[0]) a_q <= a_q >> 1;
                else if (!b_q[0]) b_q <= b_q >> 1;
                else if (a_q == b_q) begin
`ifdef GCD_LCM_EN
                    g_q <= a_q << k_q;
                    rem_q <= '0;
                    quo_q <= xm_q;
                    cnt_q <= '0;
                    state_q <= DIV;
`else
                    xo_q <= a_q << k_q;
                    rdy_q <= 1'b1;
                    busy_q <= 1'b0;
                    state_q <= DONE;
`endif
                end else if (a_q > b_q) a_q <= a_q - b_q;
                else b_q <= b_q - a_q;
`ifdef GCD_LCM_EN
                DIV: begin
                    rem_q <= ge_d ? NBits'(shift_d - {1'b0, g_q}) : shift_d[NBits-1:0];
                    quo_q <= {quo_q[NBits-2:0], ge_d};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == KW'(NBits - 1)) begin
                        cnt_q <= '0;
                        acc_q <= '0;
                        mc_q <= {{NBits{1'b0}}, ym_q};
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    mc_q <= mc_q << 1;
                    quo_q <= quo_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == KW'(NBits - 1)) begin
                        xo_q <= g_q;
                        lo_q <= acc_d;
                        rdy_q <= 1'b1;
                        busy_q <= 1'b0;
                        state_q <= DONE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
    assign xo = xo_q;
    assign rdy = rdy_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_gcd_stein.sv
// tb_gcd_stein: directed and random self-check of gcd_stein (NBits=16).
// Checks lo as well when built with GCD_LCM_EN.
module tb_gcd_stein;
`ifdef GCD_LCM_EN
    localparam int BOUND = 100;
`else
    localparam int BOUND = 68;
`endif
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, sgn = 1'b0;
    logic [15:0] xi = '0, yi = '0, xo;
    logic rdy, busy;
    logic [31:0] lo_obs;
    int n_cmp = 0, n_err = 0, rdy_edges = 0;
`ifdef GCD_LCM_EN
    logic [31:0] lo;
    assign lo_obs = lo;
    gcd_stein #(.NBits(16)) dut (.clk(clk), .rst(rst), .start(start), .sgn(sgn), .xi(xi), .yi(yi),
                                 .xo(xo), .rdy(rdy), .busy(busy), .lo(lo));
`else
    assign lo_obs = '0;
    gcd_stein #(.NBits(16)) dut (.clk(clk), .rst(rst), .start(start), .sgn(sgn), .xi(xi), .yi(yi),
                                 .xo(xo), .rdy(rdy), .busy(busy));
`endif
    always #5 clk = ~clk;
    always @(posedge rdy) rdy_edges++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input string tag, input int exact);
        int cyc = 0;
        while (!rdy && cyc < BOUND + 10) begin
            @(posedge clk);
            #1 cyc++;
        end
        if (exact > 0) check({tag, "/lat"}, 64'(cyc), 64'(exact));
        else check({tag, "/lat_ok"}, 64'(cyc <= BOUND), 64'd1);
    endtask

    task automatic finish_check(input string tag, input logic [15:0] eg, input logic [31:0] el, input int e0);
        check({tag, "/xo"}, 64'(xo), 64'(eg));
        check({tag, "/rdy"}, 64'(rdy), 64'd1);
        check({tag, "/busy"}, 64'(busy), 64'd0);
        check({tag, "/edges"}, 64'(rdy_edges), 64'(e0 + 1));
`ifdef GCD_LCM_EN
        check({tag, "/lo"}, 64'(lo_obs), 64'(el));
`endif
    endtask

    task automatic run(input string tag, input logic [15:0] x, input logic [15:0] y, input logic s,
                       input logic [15:0] eg, input logic [31:0] el, input int exact);
        int e0;
        @(negedge clk);
        xi = x; yi = y; sgn = s; start = 1'b1;
        e0 = rdy_edges;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "/busy_on"}, 64'(busy), 64'd1);
        wait_rdy(tag, exact);
        finish_check(tag, eg, el, e0);
    endtask

    function automatic logic [15:0] mag(input logic [15:0] v, input logic s);
        return (s && v[15]) ? 16'(-v) : v;
    endfunction

    function automatic logic [15:0] ref_gcd(input logic [15:0] p, input logic [15:0] q);
        logic [15:0] t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    initial begin
        int e0;
        logic [15:0] rx, ry, g;
        logic [31:0] l;
        rst = 1'b1; start = 1'b1; xi = 16'd13; yi = 16'd7;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        check("rst/xo", 64'(xo), 64'd0);
        check("rst/rdy", 64'(rdy), 64'd0);
        check("rst/busy", 64'(busy), 64'd0);
        check("rst/lo", 64'(lo_obs), 64'd0);
        repeat (3) @(posedge clk);
        #1 check("rst/start_ignored", 64'(busy), 64'd0);

        run("g13_7", 16'd13, 16'd7, 1'b0, 16'd1, 32'd91, 0);
        run("g42_18", 16'd42, 16'd18, 1'b0, 16'd6, 32'd126, 0);
        run("g18_42", 16'd18, 16'd42, 1'b0, 16'd6, 32'd126, 0);
        run("g620", 16'd620, 16'd620, 1'b0, 16'd620, 32'd620, 0);
        run("z0_0", 16'd0, 16'd0, 1'b0, 16'd0, 32'd0, 2);
        run("z0_620", 16'd0, 16'd620, 1'b0, 16'd620, 32'd0, 2);
        run("s_n18_n42", 16'hFFEE, 16'hFFD6, 1'b1, 16'd6, 32'd126, 0);
        run("s_n18_42", 16'hFFEE, 16'd42, 1'b1, 16'd6, 32'd126, 0);
        run("s_18_n42", 16'd18, 16'hFFD6, 1'b1, 16'd6, 32'd126, 0);
        run("s_min_0", 16'h8000, 16'd0, 1'b1, 16'h8000, 32'd0, 2);
        run("raw_n18_n42", 16'hFFEE, 16'hFFD6, 1'b0, 16'd2, 32'd2145517946, 0);

        @(negedge clk);
        xi = 16'd42; yi = 16'd18; sgn = 1'b0; start = 1'b1;
        e0 = rdy_edges;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1; xi = 16'd13; yi = 16'd7;
        @(posedge clk);
        #1 start = 1'b0;
        wait_rdy("midstart", 0);
        finish_check("midstart", 16'd6, 32'd126, e0);

        run("pre_rst", 16'd620, 16'd620, 1'b0, 16'd620, 32'd620, 0);
        @(negedge clk);
        xi = 16'd42; yi = 16'd18; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst/xo", 64'(xo), 64'd0);
        check("midrst/rdy", 64'(rdy), 64'd0);
        check("midrst/busy", 64'(busy), 64'd0);
        check("midrst/lo", 64'(lo_obs), 64'd0);
        run("post_rst", 16'd13, 16'd7, 1'b0, 16'd1, 32'd91, 0);

        for (int i = 0; i < 200; i++) begin
            rx = 16'($urandom_range(0, 32767));
            ry = 16'($urandom_range(0, 32767));
            if ($urandom_range(0, 1) == 1) rx = -rx;
            if ($urandom_range(0, 1) == 1) ry = -ry;
            g = ref_gcd(mag(rx, i[0]), mag(ry, i[0]));
            l = (g == 0) ? 32'd0 : 32'(mag(rx, i[0]) / g) * 32'(mag(ry, i[0]));
            run($sformatf("rnd%0d", i), rx, ry, i[0], g, l, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
